// File: rtl/div_arb.sv
// div_arb: round-robin arbiter that shares one unsigned iterative divider
// between NREQ requesters. Signed operations are handled here by feeding
// the divider magnitudes and fixing the signs of quotient and remainder.
module div_arb #(
    parameter int DSZ  = 32,
    parameter int NREQ = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*DSZ-1:0] req_x,
    input  logic [NREQ*DSZ-1:0] req_y,
    input  logic [NREQ-1:0]     req_sgn,
    output logic [NREQ-1:0]     rsp_valid,
    input  logic [NREQ-1:0]     rsp_ready,
    output logic [DSZ-1:0]      rsp_q,
    output logic [DSZ-1:0]      rsp_r,
    output logic                rsp_dbz,
    output logic                div_start,
    output logic [DSZ-1:0]      div_x,
    output logic [DSZ-1:0]      div_y,
    input  logic                div_busy,
    input  logic                div_dbz,
    input  logic [DSZ-1:0]      div_q,
    input  logic [DSZ-1:0]      div_r
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {IDLE, START, WAIT, FIX, RESP} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;      // index of the last granted requester
    logic [PW-1:0]   gnt_q, gnt_d;      // requester owning the op in flight
    logic [DSZ-1:0]  xraw_q, xraw_d;    // raw dividend, returned as remainder on /0
    logic            xneg_q, xneg_d;
    logic            yneg_q, yneg_d;
    logic [DSZ-1:0]  dx_q, dx_d;
    logic [DSZ-1:0]  dy_q, dy_d;
    logic [DSZ-1:0]  q_q, q_d;
    logic [DSZ-1:0]  r_q, r_d;
    logic            dbz_q, dbz_d;

    logic            gnt_found;
    logic [PW-1:0]   gnt_idx;
    logic [PW-1:0]   cand;
    logic [DSZ-1:0]  sel_x, sel_y;
    logic            sel_sgn;

    // Two's-complement negate; the most-negative value maps onto itself.
    function automatic logic [DSZ-1:0] neg2c(input logic [DSZ-1:0] v);
        return ~v + DSZ'(1);
    endfunction

    // Magnitude of an operand for the unsigned divider.
    function automatic logic [DSZ-1:0] mag(input logic [DSZ-1:0] v, input logic sgn);
        return (sgn && v[DSZ-1]) ? neg2c(v) : v;
    endfunction

    assign rsp_q   = q_q;
    assign rsp_r   = r_q;
    assign rsp_dbz = dbz_q;
    assign div_x   = dx_q;
    assign div_y   = dy_q;

    // Round-robin pick: first valid requester after the last grant.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = PW'((int'(ptr_q) + i) % NREQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
        sel_x   = req_x[int'(gnt_idx)*DSZ +: DSZ];
        sel_y   = req_y[int'(gnt_idx)*DSZ +: DSZ];
        sel_sgn = req_sgn[gnt_idx];
    end

    // Next-state and handshake outputs of the arbitration/sign-fix FSM.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        xraw_d    = xraw_q;
        xneg_d    = xneg_q;
        yneg_d    = yneg_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        q_d       = q_q;
        r_d       = r_q;
        dbz_d     = dbz_q;
        req_ready = '0;
        rsp_valid = '0;
        div_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    req_ready[gnt_idx] = !rst;
                    ptr_d   = gnt_idx;
                    gnt_d   = gnt_idx;
                    xraw_d  = sel_x;
                    xneg_d  = sel_sgn & sel_x[DSZ-1];
                    yneg_d  = sel_sgn & sel_y[DSZ-1];
                    dx_d    = mag(sel_x, sel_sgn);
                    dy_d    = mag(sel_y, sel_sgn);
                    state_d = START;
                end
            end
            START: begin
                div_start = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                if (div_dbz) begin
                    dbz_d   = 1'b1;
                    q_d     = '0;
                    r_d     = xraw_q;
                    state_d = RESP;
                end else if (!div_busy) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // Truncating division: remainder follows the dividend's sign.
                q_d     = (xneg_q ^ yneg_q) ? neg2c(div_q) : div_q;
                r_d     = xneg_q ? neg2c(div_r) : div_r;
                dbz_d   = 1'b0;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid[gnt_q] = 1'b1;
                if (rsp_ready[gnt_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset gives requester 0 first priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= PW'(NREQ - 1);
            gnt_q   <= '0;
            xraw_q  <= '0;
            xneg_q  <= 1'b0;
            yneg_q  <= 1'b0;
            dx_q    <= '0;
            dy_q    <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            xraw_q  <= xraw_d;
            xneg_q  <= xneg_d;
            yneg_q  <= yneg_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
        end
    end

endmodule

// File: tb/tb_div_arb.sv
// tb_div_arb: directed vectors for div_arb with a behavioural divider model
// (busy for DSZ cycles after start; divide-by-zero flagged one cycle later).
module tb_div_arb;

    localparam int DSZ  = 32;
    localparam int NREQ = 2;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*DSZ-1:0] req_x;
    logic [NREQ*DSZ-1:0] req_y;
    logic [NREQ-1:0]     req_sgn;
    logic [NREQ-1:0]     rsp_valid;
    logic [NREQ-1:0]     rsp_ready;
    logic [DSZ-1:0]      rsp_q;
    logic [DSZ-1:0]      rsp_r;
    logic                rsp_dbz;
    logic                div_start;
    logic [DSZ-1:0]      div_x;
    logic [DSZ-1:0]      div_y;
    logic                div_busy;
    logic                div_dbz;
    logic [DSZ-1:0]      div_q;
    logic [DSZ-1:0]      div_r;

    int n_chk;
    int n_fail;

    // divider model state
    logic [DSZ-1:0] m_a, m_b;
    int             m_cnt;
    logic           m_zero;

    div_arb #(.DSZ(DSZ), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_sgn(req_sgn),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_dbz(rsp_dbz),
        .div_start(div_start), .div_x(div_x), .div_y(div_y),
        .div_busy(div_busy), .div_dbz(div_dbz), .div_q(div_q), .div_r(div_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        div_busy = 1'b0;
        div_dbz  = 1'b0;
        div_q    = '0;
        div_r    = '0;
        m_a      = '0;
        m_b      = '0;
        m_cnt    = 0;
        m_zero   = 1'b0;
    end

    // Shared divider model, restarted only by div_start.
    always @(posedge clk) begin
        if (div_start) begin
            m_a      <= div_x;
            m_b      <= div_y;
            m_cnt    <= DSZ;
            m_zero   <= (div_y == '0);
            div_busy <= 1'b1;
            div_dbz  <= 1'b0;
        end else if (div_busy) begin
            if (m_zero) begin
                div_dbz  <= 1'b1;
                div_busy <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    div_busy <= 1'b0;
                    div_q    <= m_a / m_b;
                    div_r    <= m_a % m_b;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One transaction on requester idx; optionally stall rsp_ready for hold cycles.
    task automatic run_op(input int idx, input logic [DSZ-1:0] x, input logic [DSZ-1:0] y,
                          input logic s, input logic [DSZ-1:0] eq, input logic [DSZ-1:0] er,
                          input logic edbz, input int elat, input int hold);
        int lat;
        bit got;
        bit ok;
        int oth;
        logic [DSZ-1:0] dx, dy;
        dx  = (s && x[DSZ-1]) ? (~x + 1) : x;
        dy  = (s && y[DSZ-1]) ? (~y + 1) : y;
        oth = idx ^ 1;
        @(negedge clk);
        req_x[idx*DSZ +: DSZ] = x;
        req_y[idx*DSZ +: DSZ] = y;
        req_sgn[idx]          = s;
        req_valid[idx]        = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (req_ready[idx]) got = 1;
            else @(negedge clk);
        end
        check("grant", got, 1);
        if (!got) begin
            req_valid[idx] = 1'b0;
            return;
        end
        check("ready_onehot", req_ready, 64'(1 << idx));
        @(posedge clk);
        #1 req_valid[idx] = 1'b0;
        got = 0;
        lat = 0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                check("div_start", div_start, 1);
                check("div_x", div_x, dx);
                check("div_y", div_y, dy);
            end
            if (lat == 2) check("start_pulse", div_start, 0);
            if (rsp_valid != '0) got = 1;
        end
        check("rsp_seen", got, 1);
        if (!got) return;
        check("latency", lat, elat);
        check("rsp_valid", rsp_valid, 64'(1 << idx));
        check("rsp_q", rsp_q, eq);
        check("rsp_r", rsp_r, er);
        check("rsp_dbz", rsp_dbz, edbz);
        if (hold > 0) begin
            req_x[oth*DSZ +: DSZ] = 32'd1;
            req_y[oth*DSZ +: DSZ] = 32'd1;
            req_valid[oth]        = 1'b1;
            rsp_ready[oth]        = 1'b1;
            ok = 1;
            repeat (hold) begin
                @(negedge clk);
                if (rsp_valid != NREQ'(1 << idx) || rsp_q != eq || rsp_r != er ||
                    rsp_dbz != edbz || req_ready != '0)
                    ok = 0;
            end
            check("hold_stable", ok, 1);
            req_valid[oth] = 1'b0;
            rsp_ready[oth] = 1'b0;
        end
        rsp_ready[idx] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[idx] = 1'b0;
        @(negedge clk);
        check("rsp_drop", rsp_valid, 0);
    endtask

    initial begin
        bit ok;
        bit got;
        int g;
        n_chk     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        req_valid = '1;
        req_x     = '0;
        req_y     = '0;
        req_sgn   = '0;
        rsp_ready = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_div_start", div_start, 0);
        check("rst_rsp_q", rsp_q, 0);
        check("rst_rsp_r", rsp_r, 0);
        check("rst_rsp_dbz", rsp_dbz, 0);
        check("rst_div_x", div_x, 0);
        check("rst_div_y", div_y, 0);
        req_valid = '0;
        rst       = 1'b0;

        // unsigned 100/7
        run_op(0, 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, DSZ + 4, 0);
        // signed -7/2
        run_op(1, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, DSZ + 4, 0);
        // divide by zero, lone requester 1 while pointer favours 0
        run_op(1, 32'd5, 32'd0, 1'b0, 32'd0, 32'd5, 1'b1, 4, 0);
        // most-negative / -1 with a stalled response
        run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, DSZ + 4, 10);

        // reset while the divider is busy
        @(negedge clk);
        req_x[31:0]  = 32'd100;
        req_y[31:0]  = 32'd7;
        req_sgn[0]   = 1'b0;
        req_valid[0] = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (req_ready[0]) got = 1;
            else @(negedge clk);
        end
        check("rst_op_grant", got, 1);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        repeat (5) @(negedge clk);
        check("wait_no_rsp", rsp_valid, 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_rsp_q", rsp_q, 0);
        check("midrst_div_x", div_x, 0);
        ok = 1;
        repeat (45) begin
            @(negedge clk);
            if (rsp_valid != '0 || div_start) ok = 0;
        end
        check("no_stale", ok, 1);
        run_op(0, 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, DSZ + 4, 0);

        // round robin with both requesters continuously valid
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        req_x     = {32'd50, 32'd100};
        req_y     = {32'd5, 32'd7};
        req_sgn   = '0;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            got = 0;
            for (int i = 0; i < 20 && !got; i++) begin
                #1;
                if (req_ready != '0) got = 1;
                else @(negedge clk);
            end
            check("rr_grant_seen", got, 1);
            g = req_ready[1] ? 1 : 0;
            check("rr_grant", g, k % 2);
            @(posedge clk);
            #1;
            got = 0;
            for (int i = 0; i < 100 && !got; i++) begin
                @(negedge clk);
                if (rsp_valid != '0) got = 1;
            end
            check("rr_rsp_seen", got, 1);
            check("rr_rsp_valid", rsp_valid, 64'(1 << (k % 2)));
            check("rr_rsp_q", rsp_q, (k % 2) ? 32'd10 : 32'd14);
            rsp_ready[g] = 1'b1;
            @(posedge clk);
            #1 rsp_ready = '0;
        end
        req_valid = '0;
        @(negedge clk);
        check("rr_idle", rsp_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/div_arb.md
DIV_ARB -- requirements
Module: div_arb

Interface
REQ-001 SHALL have parameter DSZ, default 32, operand/result width.
REQ-002 SHALL have parameter NREQ, default 2, number of requesters (2..8).
REQ-003 SHALL have port clk  input  1  clock; all logic is sampled on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester request valid.
REQ-006 SHALL have port req_ready  output  NREQ  one-hot accept pulse.
REQ-007 SHALL have port req_x  input  NREQ*DSZ  dividends, requester k at bits [k*DSZ +: DSZ].
REQ-008 SHALL have port req_y  input  NREQ*DSZ  divisors, same packing as req_x.
REQ-009 SHALL have port req_sgn  input  NREQ  1 = signed two's-complement op, 0 = unsigned.
REQ-010 SHALL have port rsp_valid  output  NREQ  one-hot response valid.
REQ-011 SHALL have port rsp_ready  input  NREQ  per-requester response accept.
REQ-012 SHALL have port rsp_q, rsp_r  output  DSZ each  quotient and remainder.
REQ-013 SHALL have port rsp_dbz  output  1  divide-by-zero flag for the response.
REQ-014 SHALL have port div_start  output  1  start pulse to the shared divider.
REQ-015 SHALL have port div_x, div_y  output  DSZ each  unsigned magnitudes to the divider.
REQ-016 SHALL have ports div_busy, div_dbz (input, 1 each) and div_q, div_r (input, DSZ each) from the divider.

Function
REQ-017 SHALL implement FSM states IDLE, START, WAIT, FIX, RESP.
REQ-018 IDLE: if any req_valid is set, SHALL grant round-robin starting from the index after the last grant; SHALL pulse req_ready[g] for 1 cycle; SHALL latch x, y, sgn and grant id g; SHALL then go to START.
REQ-019 On latch, SHALL store div_x=|x| and div_y=|y| when sgn=1 (two's-complement negate if MSB set), else the raw values; SHALL also store xneg=sgn&x[MSB] and yneg=sgn&y[MSB].
REQ-020 START: SHALL hold div_start=1 for exactly 1 cycle with div_x/div_y stable, then go to WAIT; div_x/div_y SHALL stay stable until FIX.
REQ-021 WAIT: if div_dbz=1, SHALL go to RESP with rsp_dbz=1, rsp_q=0, rsp_r=latched raw x; else if div_busy=0, SHALL go to FIX; else SHALL stay in WAIT.
REQ-022 FIX: SHALL set rsp_q = (xneg^yneg) ? -div_q : div_q and rsp_r = xneg ? -div_r : div_r (truncating division; the remainder takes the sign of the dividend); SHALL set rsp_dbz=0; SHALL then go to RESP.
REQ-023 For signed most-negative / -1, SHALL return q=most-negative (two's-complement wrap) and r=0, with rsp_dbz=0.
REQ-024 RESP: SHALL hold rsp_valid[g]=1 and keep rsp_q/rsp_r/rsp_dbz stable until rsp_ready[g]=1; the cycle after the handshake, SHALL return to IDLE and deassert rsp_valid.
REQ-025 Non-zero divisor latency: rsp_valid SHALL first assert exactly DSZ+4 cycles after the cycle in which req_ready pulsed.
REQ-026 Zero divisor latency: rsp_valid SHALL assert 4 cycles after the req_ready pulse.
REQ-027 SHALL accept at most one request in flight; req_ready SHALL be 0 outside IDLE.
REQ-028 SHALL update the round-robin pointer only on a grant.
REQ-029 A request deasserted before it is granted SHALL be dropped without any response.
REQ-030 rsp_ready on a non-granted index, or outside RESP, SHALL be ignored.
REQ-031 With only one requester valid, SHALL grant it regardless of pointer position.

Reset
REQ-032 On rst, SHALL go to IDLE and set req_ready=0, rsp_valid=0, div_start=0, rsp_q=0, rsp_r=0, rsp_dbz=0, div_x=0, div_y=0.
REQ-033 On rst, SHALL set the round-robin pointer so that requester 0 has first priority.
REQ-034 rst mid-operation SHALL discard the in-flight op with no response; the divider SHALL be re-initialized only by the next div_start, and div_busy SHALL be ignored in IDLE.

Verification
REQ-035 Test: req 0 unsigned x=100, y=7 -> rsp_valid[0] at +36 cycles (DSZ=32), q=14, r=2, dbz=0.
REQ-036 Test: req 1 signed x=-7 (0xFFFFFFF9), y=2 -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1).
REQ-037 Test: y=0, x=5 -> rsp_valid at +4 cycles, dbz=1, q=0, r=5.
REQ-038 Test: req 0 and req 1 both valid continuously, 4 ops -> grant order 0,1,0,1, each response tagged to the correct requester.
REQ-039 Test: signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0; rsp_ready held low for 10 cycles -> outputs stable, no new grant.
REQ-040 Test: rst asserted in WAIT, then new request 9/3 -> no stale response; result q=3, r=0 with correct latency.
